// File: rtl/gpu_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpu_cmd_pkg
// Brief   : Shared types and constants for the GPU command dispatcher:
//           opcode, job-type and FSM-state encodings, field widths and
//           opcode classification helpers.
// Revision: 1.0 - initial release
// ============================================================================
package gpu_cmd_pkg;

  localparam int COORD_W = 14;
  localparam int COLOR_W = 24;
  localparam int PARAM_W = 28;
  localparam int CMD_W   = 32;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_SET_COLOR = 4'd1,
    OP_SET_A     = 4'd2,
    OP_SET_B     = 4'd3,
    OP_DRAW_LINE = 4'd4,
    OP_FILL_RECT = 4'd5,
    OP_CLEAR     = 4'd6
  } opcode_e;

  typedef enum logic [1:0] {
    JOB_LINE  = 2'd0,
    JOB_RECT  = 2'd1,
    JOB_CLEAR = 2'd2
  } job_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2
  } state_e;

  // Opcodes that produce a rasterizer job.
  function automatic logic is_draw_op(input logic [3:0] op);
    return (op == OP_DRAW_LINE) || (op == OP_FILL_RECT) || (op == OP_CLEAR);
  endfunction

  // Every encoding above CLEAR is undefined.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_CLEAR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : gpu_cmd_fifo
// Brief   : Command queue. Power-of-two depth, wrapping pointers, occupancy
//           count. A push while full is accepted only if a pop happens in
//           the same cycle; a pop while empty is ignored.
// Revision: 1.0 - initial release
// ============================================================================
module gpu_cmd_fifo
  import gpu_cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [CMD_W-1:0]       din,
  output logic [CMD_W-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic [CMD_W-1:0] r_mem [DEPTH];
  logic             w_rd;
  logic             w_wr;

  assign empty = (r_count == '0);
  assign full  = (r_count == DEPTH[c_aw:0]);
  assign w_rd  = pop & ~empty;
  assign w_wr  = push & (~full | w_rd);
  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpu_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : gpu_cmd_dispatch
// Brief   : Queues APB command strobes, decodes them one per cycle into
//           colour/vertex shadow registers and hands draw jobs to the
//           rasterizer over a valid/ready handshake.
//           Optional: define GPU_CMD_ILLEGAL_CNT_EN to add the 8-bit
//           saturating illegal_count_o output.
// Revision: 1.0 - initial release
// ============================================================================
module gpu_cmd_dispatch
  import gpu_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        command_i,
  input  logic [3:0]                  opcode_i,
  input  logic [PARAM_W-1:0]          parameters_i,
  output logic                        job_valid_o,
  input  logic                        job_ready_i,
  output logic [1:0]                  job_type_o,
  output logic [COORD_W-1:0]          job_x0_o,
  output logic [COORD_W-1:0]          job_y0_o,
  output logic [COORD_W-1:0]          job_x1_o,
  output logic [COORD_W-1:0]          job_y1_o,
  output logic [COLOR_W-1:0]          job_color_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        overflow_o,
`ifdef GPU_CMD_ILLEGAL_CNT_EN
  output logic [7:0]                  illegal_count_o,
`endif
  output logic                        illegal_o
);

  localparam int         c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] c_st_idle   = ST_IDLE;
  localparam logic [1:0] c_st_decode = ST_DECODE;
  localparam logic [1:0] c_st_issue  = ST_ISSUE;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_more;
  logic               w_draw;
  logic               w_illegal;
  logic [c_cnt_w-1:0] w_count;
  logic [CMD_W-1:0]   w_head;
  logic [3:0]         w_head_op;
  logic [PARAM_W-1:0] w_head_par;

  logic [COLOR_W-1:0] r_color;
  logic [COORD_W-1:0] r_xa, r_ya, r_xb, r_yb;
  logic [1:0]         r_job_type;
  logic [COORD_W-1:0] r_job_x0, r_job_y0, r_job_x1, r_job_y1;
  logic [COLOR_W-1:0] r_job_color;
  logic               r_overflow;

  assign w_head_op  = w_head[CMD_W-1:PARAM_W];
  assign w_head_par = w_head[PARAM_W-1:0];

  // Only DECODE consumes entries; a full queue still accepts when it pops.
  assign w_pop     = (r_state == c_st_decode) & ~w_empty;
  assign w_push    = command_i & (~w_full | w_pop);
  assign w_draw    = w_pop & is_draw_op(w_head_op);
  assign w_illegal = w_pop & is_illegal_op(w_head_op);

  // Queue will hold at least one entry after this edge (counts a same-cycle
  // push, which is what gives a two-cycle strobe-to-valid latency from IDLE).
  assign w_more = w_push || (w_count > {{(c_cnt_w-1){1'b0}}, w_pop});

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({opcode_i, parameters_i}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Next-state selection for the IDLE/DECODE/ISSUE sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:   w_state_next = w_more ? c_st_decode : c_st_idle;
      c_st_decode: begin
        if (w_draw)      w_state_next = c_st_issue;
        else if (w_more) w_state_next = c_st_decode;
        else             w_state_next = c_st_idle;
      end
      c_st_issue: begin
        if (job_ready_i) w_state_next = w_more ? c_st_decode : c_st_idle;
      end
      default:     w_state_next = c_st_idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= c_st_idle;
    else        r_state <= w_state_next;
  end

  // Shadow registers change only when a SET_* entry is decoded.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_color <= '0;
      r_xa    <= '0;
      r_ya    <= '0;
      r_xb    <= '0;
      r_yb    <= '0;
    end else if (w_pop) begin
      case (w_head_op)
        OP_SET_COLOR: r_color <= w_head_par[COLOR_W-1:0];
        OP_SET_A: begin
          r_xa <= w_head_par[PARAM_W-1:COORD_W];
          r_ya <= w_head_par[COORD_W-1:0];
        end
        OP_SET_B: begin
          r_xb <= w_head_par[PARAM_W-1:COORD_W];
          r_yb <= w_head_par[COORD_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Job registers load on a draw decode and stay frozen through ISSUE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_job_type  <= '0;
      r_job_x0    <= '0;
      r_job_y0    <= '0;
      r_job_x1    <= '0;
      r_job_y1    <= '0;
      r_job_color <= '0;
    end else if (w_draw) begin
      r_job_color <= r_color;
      if (w_head_op == OP_CLEAR) begin
        r_job_type <= JOB_CLEAR;
        r_job_x0   <= '0;
        r_job_y0   <= '0;
        r_job_x1   <= '0;
        r_job_y1   <= '0;
      end else begin
        r_job_type <= (w_head_op == OP_DRAW_LINE) ? JOB_LINE : JOB_RECT;
        r_job_x0   <= r_xa;
        r_job_y0   <= r_ya;
        r_job_x1   <= r_xb;
        r_job_y1   <= r_yb;
      end
    end
  end

  // Sticky flag for a strobe lost to a full queue with no pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                          r_overflow <= 1'b0;
    else if (command_i && w_full && !w_pop) r_overflow <= 1'b1;
  end

`ifdef GPU_CMD_ILLEGAL_CNT_EN
  logic [7:0] r_illegal_cnt;

  // Saturating tally of illegal-opcode pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                r_illegal_cnt <= '0;
    else if (w_illegal && r_illegal_cnt != 8'hFF) r_illegal_cnt <= r_illegal_cnt + 8'd1;
  end

  assign illegal_count_o = r_illegal_cnt;
`endif

  assign job_valid_o  = (r_state == c_st_issue);
  assign job_type_o   = r_job_type;
  assign job_x0_o     = r_job_x0;
  assign job_y0_o     = r_job_y0;
  assign job_x1_o     = r_job_x1;
  assign job_y1_o     = r_job_y1;
  assign job_color_o  = r_job_color;
  assign busy_o       = (r_state != c_st_idle) | ~w_empty;
  assign fifo_count_o = w_count;
  assign overflow_o   = r_overflow;
  assign illegal_o    = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpu_cmd_dispatch
// Brief   : Self-checking bench for gpu_cmd_dispatch: queue-based reference
//           model compared every cycle, directed scenarios with literal
//           expectations, then randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpu_cmd_dispatch;
  import gpu_cmd_pkg::*;

  localparam int DEPTH = 8;
  localparam int M_IDLE = 0, M_DECODE = 1, M_ISSUE = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        command_i = 1'b0;
  logic [3:0]  opcode_i = '0;
  logic [27:0] parameters_i = '0;
  logic        job_ready_i = 1'b0;
  logic        job_valid_o;
  logic [1:0]  job_type_o;
  logic [13:0] job_x0_o, job_y0_o, job_x1_o, job_y1_o;
  logic [23:0] job_color_o;
  logic        busy_o;
  logic [3:0]  fifo_count_o;
  logic        overflow_o;
  logic        illegal_o;
`ifdef GPU_CMD_ILLEGAL_CNT_EN
  logic [7:0]  illegal_count_o;
`endif

  always #5 clk = ~clk;

  gpu_cmd_dispatch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .command_i       (command_i),
    .opcode_i        (opcode_i),
    .parameters_i    (parameters_i),
    .job_valid_o     (job_valid_o),
    .job_ready_i     (job_ready_i),
    .job_type_o      (job_type_o),
    .job_x0_o        (job_x0_o),
    .job_y0_o        (job_y0_o),
    .job_x1_o        (job_x1_o),
    .job_y1_o        (job_y1_o),
    .job_color_o     (job_color_o),
    .busy_o          (busy_o),
    .fifo_count_o    (fifo_count_o),
    .overflow_o      (overflow_o),
`ifdef GPU_CMD_ILLEGAL_CNT_EN
    .illegal_count_o (illegal_count_o),
`endif
    .illegal_o       (illegal_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue + shadow state ----------------
  logic [31:0] mq[$];
  int          m_mode;
  logic [23:0] m_color;
  logic [13:0] m_xa, m_ya, m_xb, m_yb;
  logic [1:0]  m_jt;
  logic [13:0] m_jx0, m_jy0, m_jx1, m_jy1;
  logic [23:0] m_jc;
  bit          m_ovf;
  int          m_icnt;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      m_mode = M_IDLE;
      m_color = '0; m_xa = '0; m_ya = '0; m_xb = '0; m_yb = '0;
      m_jt = '0; m_jx0 = '0; m_jy0 = '0; m_jx1 = '0; m_jy1 = '0; m_jc = '0;
      m_ovf = 0;
      m_icnt = 0;
    end else begin
      logic [31:0] h;
      logic [3:0]  op;
      bit          draw;
      bit          more;
      draw = 0;
      if (m_mode == M_DECODE && mq.size() != 0) begin
        h  = mq.pop_front();
        op = h[31:28];
        case (op)
          4'd0: ;
          4'd1: m_color = h[23:0];
          4'd2: begin m_xa = h[27:14]; m_ya = h[13:0]; end
          4'd3: begin m_xb = h[27:14]; m_yb = h[13:0]; end
          4'd4, 4'd5: begin
            draw = 1; m_jc = m_color; m_jt = (op == 4'd4) ? 2'd0 : 2'd1;
            m_jx0 = m_xa; m_jy0 = m_ya; m_jx1 = m_xb; m_jy1 = m_yb;
          end
          4'd6: begin
            draw = 1; m_jc = m_color; m_jt = 2'd2;
            m_jx0 = '0; m_jy0 = '0; m_jx1 = '0; m_jy1 = '0;
          end
          default: if (m_icnt < 255) m_icnt++;
        endcase
      end
      if (command_i) begin
        if (mq.size() < DEPTH) mq.push_back({opcode_i, parameters_i});
        else m_ovf = 1;
      end
      more = (mq.size() != 0);
      case (m_mode)
        M_IDLE:   m_mode = more ? M_DECODE : M_IDLE;
        M_DECODE: m_mode = draw ? M_ISSUE : (more ? M_DECODE : M_IDLE);
        default:  if (job_ready_i) m_mode = more ? M_DECODE : M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [31:0] hd;
    bit exp_ill;
    exp_ill = 0;
    if (m_mode == M_DECODE && mq.size() != 0) begin
      hd = mq[0];
      exp_ill = (hd[31:28] > 4'd6);
    end
    chk("count", fifo_count_o, mq.size());
    chk("busy", busy_o, (m_mode != M_IDLE) || (mq.size() != 0));
    chk("valid", job_valid_o, m_mode == M_ISSUE);
    chk("overflow", overflow_o, m_ovf);
    chk("illegal", illegal_o, exp_ill);
`ifdef GPU_CMD_ILLEGAL_CNT_EN
    chk("illegal_count", illegal_count_o, m_icnt);
`endif
    if (m_mode == M_ISSUE) begin
      chk("job_type", job_type_o, m_jt);
      chk("job_x0", job_x0_o, m_jx0);
      chk("job_y0", job_y0_o, m_jy0);
      chk("job_x1", job_x1_o, m_jx1);
      chk("job_y1", job_y1_o, m_jy1);
      chk("job_color", job_color_o, m_jc);
    end
  end

  // Handshake and illegal-pulse monitors (ready is stable across negedge).
  int          n_jobs = 0;
  int          n_ill = 0;
  logic [1:0]  lj_type;
  logic [13:0] lj_x0, lj_y0, lj_x1, lj_y1;
  logic [23:0] lj_color;
  always @(negedge clk) begin
    if (illegal_o) n_ill++;
    if (job_valid_o && job_ready_i) begin
      n_jobs++;
      lj_type = job_type_o; lj_x0 = job_x0_o; lj_y0 = job_y0_o;
      lj_x1 = job_x1_o; lj_y1 = job_y1_o; lj_color = job_color_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc1();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] op, input logic [27:0] p);
    command_i = 1'b1; opcode_i = op; parameters_i = p;
    cyc1();
    command_i = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #2;
    n_rst = 1'b0;
    @(posedge clk); #2;
    n_rst = 1'b1;
  endtask

  int base_jobs;
  int base_ill;

  initial begin
    #1 n_rst = 1'b0;
    #2;
    chk("rst valid", job_valid_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst count", fifo_count_o, 0);
    chk("rst overflow", overflow_o, 0);
    chk("rst illegal", illegal_o, 0);
    chk("rst job_x1", job_x1_o, 0);
    chk("rst color", job_color_o, 0);
    @(posedge clk); #2;
    n_rst = 1'b1;
    cyc1();

    // Line job with ready held high; valid two cycles after the DRAW strobe.
    job_ready_i = 1'b1;
    base_jobs = n_jobs;
    send(4'd1, 28'hFF8000);
    send(4'd2, {14'd10, 14'd20});
    send(4'd3, {14'd300, 14'd200});
    send(4'd4, 28'd0);
    @(negedge clk); chk("line valid N+1", job_valid_o, 0);
    cyc1();
    @(negedge clk);
    chk("line valid N+2", job_valid_o, 1);
    chk("line type", job_type_o, 0);
    chk("line x0", job_x0_o, 10);
    chk("line y0", job_y0_o, 20);
    chk("line x1", job_x1_o, 300);
    chk("line y1", job_y1_o, 200);
    chk("line color", job_color_o, 24'hFF8000);
    repeat (3) cyc1();
    chk("line job count", n_jobs - base_jobs, 1);

    // Stalled rect: six valid cycles, a SET_A behind it must not leak in.
    job_ready_i = 1'b0;
    send(4'd5, 28'd0);
    send(4'd2, {14'd1, 14'd2});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall valid", job_valid_o, 1);
      chk("stall x0", job_x0_o, 10);
      chk("stall y0", job_y0_o, 20);
      cyc1();
    end
    job_ready_i = 1'b1;
    @(negedge clk); chk("stall valid last", job_valid_o, 1);
    cyc1();
    repeat (2) cyc1();
    send(4'd5, 28'd0);
    cyc1();
    @(negedge clk);
    chk("rect2 type", job_type_o, 1);
    chk("rect2 x0", job_x0_o, 1);
    chk("rect2 y0", job_y0_o, 2);
    chk("rect2 x1", job_x1_o, 300);
    repeat (3) cyc1();

    // Push while full with a simultaneous pop: accepted, no overflow.
    reset_dut();
    job_ready_i = 1'b0;
    send(4'd4, 28'd0);
    cyc1();
    repeat (DEPTH) send(4'd0, 28'd0);
    @(negedge clk);
    chk("full count", fifo_count_o, DEPTH);
    chk("full no overflow", overflow_o, 0);
    job_ready_i = 1'b1;
    cyc1();
    job_ready_i = 1'b0;
    send(4'd0, 28'd0);
    @(negedge clk);
    chk("pushpop count", fifo_count_o, DEPTH);
    chk("pushpop overflow", overflow_o, 0);
    job_ready_i = 1'b1;
    repeat (12) cyc1();

    // Overflow: DEPTH+2 pushes while stalled in ISSUE.
    reset_dut();
    job_ready_i = 1'b0;
    send(4'd4, 28'd0);
    cyc1();
    repeat (DEPTH + 2) send(4'd0, 28'd0);
    @(negedge clk);
    chk("ovf count", fifo_count_o, 8);
    chk("ovf flag", overflow_o, 1);
    job_ready_i = 1'b1;
    repeat (20) cyc1();
    chk("ovf sticky", overflow_o, 1);
    chk("ovf drained", fifo_count_o, 0);
    reset_dut();
    chk("ovf cleared", overflow_o, 0);

    // Illegal opcode followed by CLEAR.
    base_jobs = n_jobs;
    base_ill = n_ill;
    send(4'd2, {14'd7, 14'd9});
    send(4'd1, 28'h123456);
    send(4'd9, 28'hABCDEF0);
    send(4'd6, 28'd0);
    repeat (4) cyc1();
    chk("illegal pulses", n_ill - base_ill, 1);
    chk("clear jobs", n_jobs - base_jobs, 1);
    chk("clear type", lj_type, 2);
    chk("clear x0", lj_x0, 0);
    chk("clear y0", lj_y0, 0);
    chk("clear x1", lj_x1, 0);
    chk("clear y1", lj_y1, 0);
    chk("clear color", lj_color, 24'h123456);
`ifdef GPU_CMD_ILLEGAL_CNT_EN
    chk("illegal_count", illegal_count_o, 1);
`endif

    // Reset mid-ISSUE with three queued entries.
    job_ready_i = 1'b0;
    send(4'd4, 28'd0);
    cyc1();
    repeat (3) send(4'd0, 28'd0);
    @(negedge clk);
    chk("pre-rst valid", job_valid_o, 1);
    chk("pre-rst count", fifo_count_o, 3);
    #1 n_rst = 1'b0;
    #1;
    chk("mid-rst valid", job_valid_o, 0);
    chk("mid-rst count", fifo_count_o, 0);
    chk("mid-rst busy", busy_o, 0);
    @(posedge clk); #2;
    n_rst = 1'b1;
    base_jobs = n_jobs;
    job_ready_i = 1'b1;
    repeat (10) cyc1();
    chk("post-rst jobs", n_jobs - base_jobs, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      command_i = ($urandom_range(0, 99) < 55);
      if ($urandom_range(0, 9) == 0) opcode_i = 4'($urandom_range(7, 15));
      else                           opcode_i = 4'($urandom_range(0, 6));
      parameters_i = 28'($urandom);
      job_ready_i = ($urandom_range(0, 2) != 0);
      cyc1();
    end
    command_i = 1'b0;
    job_ready_i = 1'b1;
    repeat (40) cyc1();
    chk("final idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpu_cmd_dispatch.md
GPU_CMD_DISPATCH -- requirements
Module: gpu_cmd_dispatch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command-queue depth in entries (power of two, 2..64).
REQ-002 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports command_i (input, 1), opcode_i (input, 4) and parameters_i (input, 28): a one-cycle command strobe with its opcode and payload, from the APB interface.
REQ-005 SHALL have ports job_valid_o (output, 1) and job_ready_i (input, 1): the job handshake to the rasterizer.
REQ-006 SHALL have port job_type_o, output, 2: LINE=0, RECT=1, CLEAR=2.
REQ-007 SHALL have ports job_x0_o, job_y0_o, job_x1_o and job_y1_o, each output, 14, carrying the job coordinates.
REQ-008 SHALL have port job_color_o, output, 24, RGB888.
REQ-009 SHALL have ports busy_o (output, 1), fifo_count_o (output, $clog2(FIFO_DEPTH)+1), overflow_o (output, 1, sticky) and illegal_o (output, 1, one-cycle pulse).

Function
REQ-010 SHALL write {opcode_i, parameters_i} into the FIFO on every clock edge where command_i=1 and the FIFO is not full, or is full and popped in the same cycle.
REQ-011 SHALL drop a command that arrives while the FIFO is full with no pop, and set overflow_o=1 until reset.
REQ-012 SHALL use opcodes: 0 NOP, 1 SET_COLOR (color=param[23:0]), 2 SET_A (xA=param[27:14], yA=param[13:0]), 3 SET_B (xB, yB, same split), 4 DRAW_LINE, 5 FILL_RECT, 6 CLEAR; opcodes 7..15 are illegal.
REQ-013 SHALL use FSM states IDLE, DECODE and ISSUE.
REQ-014 IDLE SHALL go to DECODE when the FIFO is non-empty, otherwise stay in IDLE.
REQ-015 DECODE SHALL pop the head entry, taking one cycle per entry.
REQ-016 In DECODE, SET_* SHALL update its shadow register at the end of the cycle.
REQ-017 In DECODE, NOP SHALL have no effect.
REQ-018 In DECODE, an illegal opcode SHALL pulse illegal_o for that cycle.
REQ-019 For SET_*, NOP and illegal opcodes, the next state SHALL be DECODE if the FIFO is still non-empty, else IDLE.
REQ-020 In DECODE, DRAW_LINE, FILL_RECT and CLEAR SHALL load the job output registers from the shadow registers and go to ISSUE.
REQ-021 LINE and RECT jobs SHALL use x0,y0=A and x1,y1=B.
REQ-022 CLEAR jobs SHALL drive all coordinates to 0 and carry the current color.
REQ-023 ISSUE SHALL hold job_valid_o=1 with all job_* outputs stable until the cycle where job_ready_i=1.
REQ-024 ISSUE SHALL go to DECODE on that handshake if the FIFO is non-empty, else to IDLE.
REQ-025 Pushes SHALL continue while in ISSUE; shadow registers SHALL change only in DECODE.
REQ-026 job_valid_o SHALL be 0 outside ISSUE; job_ready_i SHALL be ignored outside ISSUE.
REQ-027 Latency: a draw command strobed in cycle N with the FSM in IDLE SHALL raise job_valid_o in cycle N+2.
REQ-028 busy_o SHALL equal (state!=IDLE) OR (FIFO non-empty).
REQ-029 fifo_count_o SHALL equal the current number of stored entries.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave the count unchanged.

Reset
REQ-031 n_rst=0 SHALL asynchronously force: state=IDLE; FIFO empty; pointers=0; shadow color/A/B=0; all job_* outputs=0; job_valid_o=0; overflow_o=0; illegal_o=0; busy_o=0.
REQ-032 Reset during ISSUE SHALL abandon the pending job with no handshake; queued commands SHALL be discarded.

Configuration
REQ-033 With GPU_CMD_ILLEGAL_CNT_EN defined, the block SHALL add output illegal_count_o (8 bits), reset 0, incremented on each illegal_o pulse and saturating at 255.
REQ-034 Without GPU_CMD_ILLEGAL_CNT_EN, neither the port nor the counter SHALL exist; all other behaviour is identical.

Structure
REQ-035 Package gpu_cmd_pkg SHALL hold the opcode enum, job-type enum, FSM state enum and COORD_W=14, COLOR_W=24.
REQ-036 The FIFO SHALL be a sub-module gpu_cmd_fifo (parameter DEPTH, 32-bit data; ports push, pop, full, empty, count).

Verification
REQ-037 SET_COLOR 0xFF8000, SET_A (10,20), SET_B (300,200), DRAW_LINE, with ready held 1 -> one job: type 0, (10,20)-(300,200), color 0xFF8000, valid in cycle N+2 after the DRAW_LINE strobe.
REQ-038 FILL_RECT with job_ready_i held 0 for 5 cycles -> job_valid_o high with constant outputs for 6 cycles; a SET_A pushed meanwhile does not alter the job; the next FILL_RECT uses the new A.
REQ-039 Stall ready and push FIFO_DEPTH+2 commands -> fifo_count_o=8, 2 dropped, overflow_o=1 until reset.
REQ-040 Opcode 9 then CLEAR -> illegal_o pulses once; CLEAR job has coordinates 0 and the current color; illegal_count_o=1 when the macro is defined.
REQ-041 Assert n_rst mid-ISSUE with 3 entries queued -> job_valid_o=0 immediately, fifo_count_o=0, busy_o=0, and no job after release.
REQ-042 Push while full, with a pop in the same cycle -> accepted, count stays at 8, no overflow.
